// File: rtl/divider_pkg.sv
// Shared types and helpers for the divider arbiter slice.
// Performance counters exist only when DIVIDER_ARBITER_PERF_EN is defined.
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } div_arb_state_e;

    localparam int PERF_CNT_WIDTH = 32;

    // Saturating increment: the counter sticks at all ones.
    function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(input logic [PERF_CNT_WIDTH-1:0] value);
        return (&value) ? value : value + {{(PERF_CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/divider_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared divider.
// The master side drives requests; the slave side is the arbiter.
interface divider_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid_in;
    logic [NUM_REQ-1:0]                 req_ready_out;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_numerator_in;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_denominator_in;
    logic                               rsp_valid_out;
    logic                               rsp_ready_in;
    logic [ID_WIDTH-1:0]                rsp_id_out;
    logic [DATA_WIDTH-1:0]              rsp_quotient_out;
    logic [DATA_WIDTH-1:0]              rsp_remainder_out;
    logic                               rsp_div_zero_out;

    modport master (
        output req_valid_in, req_numerator_in, req_denominator_in, rsp_ready_in,
        input  req_ready_out, rsp_valid_out, rsp_id_out, rsp_quotient_out,
               rsp_remainder_out, rsp_div_zero_out
    );

    modport slave (
        input  req_valid_in, req_numerator_in, req_denominator_in, rsp_ready_in,
        output req_ready_out, rsp_valid_out, rsp_id_out, rsp_quotient_out,
               rsp_remainder_out, rsp_div_zero_out
    );

endinterface

// File: rtl/div_rr_arbiter.sv
// Round-robin arbiter: search starts one past last_grant and wraps.
// Produces a one-hot grant and its encoded index; idle when enable is low.
module div_rr_arbiter #(
    parameter int  NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    input  logic                enable,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx
);

    // Rotating priority search without early exit so it stays a flat mux tree
    always_comb begin
        logic                found_s;
        logic                hit_s;
        logic [ID_WIDTH-1:0] cand_s;
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        cand_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s        = ID_WIDTH'((int'(last_grant) + 32'sd1 + i) % NUM_REQ);
            hit_s         = enable & req[cand_s] & ~found_s;
            grant[cand_s] = grant[cand_s] | hit_s;
            grant_idx     = hit_s ? cand_s : grant_idx;
            found_s       = found_s | hit_s;
        end
    end

endmodule

// File: rtl/divider.sv
// Combinational unsigned divider datapath shared by all requesters.
// Callers must never present a zero denominator.
module divider #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] numerator,
    input  logic [DATA_WIDTH-1:0] denominator,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    // Quotient and remainder of the unsigned division
    always_comb begin
        quotient  = numerator / denominator;
        remainder = numerator % denominator;
    end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one divider among NUM_REQ requesters with round-robin arbitration.
// Define DIVIDER_ARBITER_PERF_EN to add saturating grant/zero-divide counters.
module divider_arbiter
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    divider_arbiter_if.slave          bus
`ifdef DIVIDER_ARBITER_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] perf_op_cnt_out,
    output logic [PERF_CNT_WIDTH-1:0] perf_zero_cnt_out
`endif
);

    localparam int ID_WIDTH = $clog2(NUM_REQ);

    div_arb_state_e        state_r;
    div_arb_state_e        state_next_s;
    logic [ID_WIDTH-1:0]   last_grant_r;
    logic [NUM_REQ-1:0]    grant_s;
    logic [ID_WIDTH-1:0]   grant_idx_s;
    logic [NUM_REQ-1:0]    ready_s;
    logic                  arb_en_s;
    logic                  grant_fire_s;
    logic [DATA_WIDTH-1:0] num_r;
    logic [DATA_WIDTH-1:0] den_r;
    logic                  den_zero_s;
    logic [DATA_WIDTH-1:0] div_den_s;
    logic [DATA_WIDTH-1:0] div_q_s;
    logic [DATA_WIDTH-1:0] div_r_s;
    logic                  rsp_valid_r;
    logic [ID_WIDTH-1:0]   rsp_id_r;
    logic [DATA_WIDTH-1:0] rsp_quotient_r;
    logic [DATA_WIDTH-1:0] rsp_remainder_r;
    logic                  rsp_div_zero_r;

    assign arb_en_s     = (state_r == ST_IDLE);
    assign grant_fire_s = |grant_s;

    div_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (bus.req_valid_in),
        .last_grant (last_grant_r),
        .enable     (arb_en_s),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    // A zero divisor is replaced by one so the datapath never divides by zero
    assign den_zero_s = (den_r == '0);
    assign div_den_s  = den_zero_s ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : den_r;

    divider #(.DATA_WIDTH(DATA_WIDTH)) u_div (
        .numerator   (num_r),
        .denominator (div_den_s),
        .quotient    (div_q_s),
        .remainder   (div_r_s)
    );

    // Next-state and combinational ready; the handshake is the grant itself
    always_comb begin
        state_next_s = state_r;
        ready_s      = '0;
        case (state_r)
            ST_IDLE: begin
                if (grant_fire_s) begin
                    state_next_s = ST_CALC;
                    ready_s      = grant_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: state_next_s = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready_in) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture on grant and registered response channel
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r    <= ID_WIDTH'(NUM_REQ - 1);
            num_r           <= '0;
            den_r           <= '0;
            rsp_valid_r     <= 1'b0;
            rsp_id_r        <= '0;
            rsp_quotient_r  <= '0;
            rsp_remainder_r <= '0;
            rsp_div_zero_r  <= 1'b0;
        end else begin
            if (grant_fire_s) begin
                num_r        <= bus.req_numerator_in[grant_idx_s];
                den_r        <= bus.req_denominator_in[grant_idx_s];
                last_grant_r <= grant_idx_s;
            end
            if (state_r == ST_CALC) begin
                rsp_valid_r     <= 1'b1;
                rsp_id_r        <= last_grant_r;
                rsp_quotient_r  <= den_zero_s ? {DATA_WIDTH{1'b1}} : div_q_s;
                rsp_remainder_r <= den_zero_s ? num_r : div_r_s;
                rsp_div_zero_r  <= den_zero_s;
            end else if ((state_r == ST_RESP) && bus.rsp_ready_in) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign bus.req_ready_out     = ready_s;
    assign bus.rsp_valid_out     = rsp_valid_r;
    assign bus.rsp_id_out        = rsp_id_r;
    assign bus.rsp_quotient_out  = rsp_quotient_r;
    assign bus.rsp_remainder_out = rsp_remainder_r;
    assign bus.rsp_div_zero_out  = rsp_div_zero_r;

`ifdef DIVIDER_ARBITER_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] perf_op_cnt_r;
    logic [PERF_CNT_WIDTH-1:0] perf_zero_cnt_r;

    // Grant and zero-divisor counters, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_op_cnt_r   <= '0;
            perf_zero_cnt_r <= '0;
        end else if (grant_fire_s) begin
            perf_op_cnt_r <= sat_inc(perf_op_cnt_r);
            if (bus.req_denominator_in[grant_idx_s] == '0) begin
                perf_zero_cnt_r <= sat_inc(perf_zero_cnt_r);
            end
        end
    end

    assign perf_op_cnt_out   = perf_op_cnt_r;
    assign perf_zero_cnt_out = perf_zero_cnt_r;
`endif

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench for divider_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_divider_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divider_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

`ifdef DIVIDER_ARBITER_PERF_EN
    logic [31:0] perf_op_cnt;
    logic [31:0] perf_zero_cnt;
`endif

    divider_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DIVIDER_ARBITER_PERF_EN
        ,
        .perf_op_cnt_out   (perf_op_cnt),
        .perf_zero_cnt_out (perf_zero_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Requester-side stimulus state
    bit          pend_v   [NR];
    logic [DW-1:0] pend_num [NR];
    logic [DW-1:0] pend_den [NR];
    bit          rearm;
    logic        rsp_rdy;

    // Reference model: one outstanding transaction, round-robin pointer
    int          m_last;
    bit          m_busy;
    int          m_age;
    int          m_id;
    logic [7:0]  m_q;
    logic [7:0]  m_r;
    bit          m_dz;
    int          m_ops;
    int          m_zeros;

    int          cyc = 0;
    int          grant_ids[$];
    int          grant_cyc[$];
    int          exp_order[5] = '{3, 0, 1, 2, 3};

    logic [NR-1:0] obs_ready;
    logic [NR-1:0] stall_ready_or;
    logic          obs_v;
    logic          obs_dz;
    logic [7:0]    obs_q;
    logic [7:0]    obs_r;
    logic [1:0]    obs_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, sample, compare against the model, advance
    task automatic cycle();
        int            g;
        logic [NR-1:0] exp_rdy;
        bit            expv;
        for (int i = 0; i < NR; i++) begin
            bus.req_valid_in[i]       = pend_v[i] && !rst;
            bus.req_numerator_in[i]   = pend_num[i];
            bus.req_denominator_in[i] = pend_den[i];
        end
        bus.rsp_ready_in = rsp_rdy;
        #1;
        obs_ready = bus.req_ready_out;
        obs_v     = bus.rsp_valid_out;
        obs_id    = bus.rsp_id_out;
        obs_q     = bus.rsp_quotient_out;
        obs_r     = bus.rsp_remainder_out;
        obs_dz    = bus.rsp_div_zero_out;
        if (rst) begin
            m_busy  = 1'b0;
            m_age   = 0;
            m_last  = NR - 1;
            m_ops   = 0;
            m_zeros = 0;
        end else begin
            g = -1;
            if (!m_busy) begin
                for (int k = 0; k < NR; k++) begin
                    int c;
                    c = (m_last + 1 + k) % NR;
                    if (g < 0 && pend_v[c]) g = c;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", obs_ready, exp_rdy);
            expv = m_busy && (m_age >= 2);
            chk("rsp_valid", obs_v, expv);
            if (expv) begin
                chk("rsp_id", obs_id, m_id);
                chk("rsp_quotient", obs_q, m_q);
                chk("rsp_remainder", obs_r, m_r);
                chk("rsp_div_zero", obs_dz, m_dz);
            end
`ifdef DIVIDER_ARBITER_PERF_EN
            chk("perf_op_cnt", perf_op_cnt, m_ops);
            chk("perf_zero_cnt", perf_zero_cnt, m_zeros);
`endif
            if (g >= 0) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_id   = g;
                m_dz   = (pend_den[g] == 8'd0);
                m_q    = m_dz ? 8'hFF : pend_num[g] / pend_den[g];
                m_r    = m_dz ? pend_num[g] : pend_num[g] % pend_den[g];
                m_last = g;
                m_ops++;
                if (m_dz) m_zeros++;
                grant_ids.push_back(g);
                grant_cyc.push_back(cyc);
                pend_v[g] = rearm;
            end else if (m_busy) begin
                if (expv && rsp_rdy) m_busy = 1'b0;
                else if (m_age < 2) m_age++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        rst     = 1'b1;
        rsp_rdy = 1'b1;
        rearm   = 1'b0;
        m_busy  = 1'b0;
        m_age   = 0;
        m_last  = NR - 1;
        m_ops   = 0;
        m_zeros = 0;
        for (int i = 0; i < NR; i++) begin
            pend_v[i]   = 1'b0;
            pend_num[i] = 8'd0;
            pend_den[i] = 8'd1;
        end
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        cycle();
        chk("reset_rsp_valid", obs_v, 1'b0);
        chk("reset_rsp_id", obs_id, 2'd0);
        chk("reset_rsp_q", obs_q, 8'd0);
        chk("reset_rsp_r", obs_r, 8'd0);
        chk("reset_rsp_dz", obs_dz, 1'b0);
        chk("reset_ready", obs_ready, 4'b0000);

        // Single request 100/7 from requester 0
        pend_v[0] = 1'b1; pend_num[0] = 8'd100; pend_den[0] = 8'd7;
        cycle();
        chk("t1_grant", obs_ready, 4'b0001);
        cycle();
        chk("t1_calc_no_rsp", obs_v, 1'b0);
        cycle();
        chk("t1_rsp_valid", obs_v, 1'b1);
        chk("t1_id", obs_id, 2'd0);
        chk("t1_q", obs_q, 8'd14);
        chk("t1_r", obs_r, 8'd2);
        chk("t1_dz", obs_dz, 1'b0);

        // Divide by zero from requester 2
        pend_v[2] = 1'b1; pend_num[2] = 8'd55; pend_den[2] = 8'd0;
        cycle();
        chk("dz_grant", obs_ready, 4'b0100);
        cycle();
        cycle();
        chk("dz_q", obs_q, 8'hFF);
        chk("dz_r", obs_r, 8'd55);
        chk("dz_flag", obs_dz, 1'b1);
        chk("dz_id", obs_id, 2'd2);

        // Fairness: all requesters continuously valid
        grant_ids.delete();
        grant_cyc.delete();
        rearm = 1'b1;
        for (int i = 0; i < NR; i++) begin
            pend_v[i] = 1'b1; pend_num[i] = 8'($urandom); pend_den[i] = 8'($urandom_range(1, 255));
        end
        repeat (15) cycle();
        rearm = 1'b0;
        chk("fair_grant_count", grant_ids.size(), 5);
        for (int k = 0; k < 5 && k < grant_ids.size(); k++) begin
            chk("fair_order", grant_ids[k], exp_order[k]);
            if (k > 0) chk("fair_spacing", grant_cyc[k] - grant_cyc[k-1], 3);
        end
        repeat (12) cycle();

        // Back-pressure while other requesters wait
        pend_v[1] = 1'b1; pend_num[1] = 8'd10; pend_den[1] = 8'd3;
        rsp_rdy = 1'b0;
        cycle();
        chk("bp_grant", obs_ready, 4'b0010);
        cycle();
        pend_v[0] = 1'b1; pend_num[0] = 8'd200; pend_den[0] = 8'd9;
        pend_v[3] = 1'b1; pend_num[3] = 8'd77;  pend_den[3] = 8'd0;
        stall_ready_or = '0;
        repeat (5) begin
            cycle();
            stall_ready_or = stall_ready_or | obs_ready;
        end
        chk("bp_no_grant", stall_ready_or, 4'b0000);
        chk("bp_valid_held", obs_v, 1'b1);
        chk("bp_q_held", obs_q, 8'd3);
        chk("bp_r_held", obs_r, 8'd1);
        rsp_rdy = 1'b1;
        cycle();
        cycle();
        chk("bp_next_grant", obs_ready, 4'b1000);
        repeat (5) cycle();

        // Reset while in the calculation state
        pend_v[2] = 1'b1; pend_num[2] = 8'd9; pend_den[2] = 8'd4;
        cycle();
        chk("rst_mid_grant", obs_ready, 4'b0100);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        pend_v[0] = 1'b1; pend_num[0] = 8'd8; pend_den[0] = 8'd2;
        pend_v[1] = 1'b1; pend_num[1] = 8'd5; pend_den[1] = 8'd5;
        cycle();
        chk("rst_mid_no_rsp", obs_v, 1'b0);
        chk("rst_mid_grant0", obs_ready, 4'b0001);
        repeat (5) cycle();

        // Ten operations, three with zero divisor, then reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            pend_v[1]   = 1'b1;
            pend_num[1] = 8'($urandom);
            pend_den[1] = (j % 3 == 2) ? 8'd0 : 8'($urandom_range(1, 255));
            repeat (3) cycle();
        end
        cycle();
`ifdef DIVIDER_ARBITER_PERF_EN
        chk("perf_ops_10", perf_op_cnt, 32'd10);
        chk("perf_zero_3", perf_zero_cnt, 32'd3);
`endif
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
`ifdef DIVIDER_ARBITER_PERF_EN
        chk("perf_ops_rst", perf_op_cnt, 32'd0);
        chk("perf_zero_rst", perf_zero_cnt, 32'd0);
`endif

        // Random traffic with random back-pressure
        repeat (400) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend_v[i] && $urandom_range(0, 3) == 0) begin
                    pend_v[i]   = 1'b1;
                    pend_num[i] = 8'($urandom);
                    pend_den[i] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
                end
            end
            rsp_rdy = ($urandom_range(0, 9) < 7);
            cycle();
        end
        rsp_rdy = 1'b1;
        repeat (40) cycle();
        chk("drain_idle", obs_v, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Shares one instance of the team's combinational `divider` datapath between NUM_REQ requesters. Arbitration is round-robin. Each requester uses a valid/ready handshake. The result is returned on a single registered response channel tagged with the requester ID. The block never presents a zero denominator to the datapath; it reports divide-by-zero on the response instead.

## Interface
Parameters:
- DATA_WIDTH, 8, operand/result width
- NUM_REQ, 4, number of requesters (≥2); ID_WIDTH = $clog2(NUM_REQ) is a localparam

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_in  in  [NUM_REQ]  per-requester request valid
- req_ready_out  out  [NUM_REQ]  per-requester accept; at most one bit high
- req_numerator_in  in  [NUM_REQ][DATA_WIDTH]  dividends
- req_denominator_in  in  [NUM_REQ][DATA_WIDTH]  divisors
- rsp_valid_out  out  1  response valid
- rsp_ready_in  in  1  response accept
- rsp_id_out  out  ID_WIDTH  index of the requester being answered
- rsp_quotient_out  out  DATA_WIDTH  quotient
- rsp_remainder_out  out  DATA_WIDTH  remainder
- rsp_div_zero_out  out  1  denominator was zero

## Operation
- FSM states: ST_IDLE, ST_CALC, ST_RESP. Reset state is ST_IDLE.
- ST_IDLE:
  - If any req_valid_in is set, the arbiter selects grant g.
  - The search starts at last_grant+1 and wraps modulo NUM_REQ.
  - req_ready_out[g]=1 combinationally in that cycle; this is the handshake.
  - The operands and g are latched, last_grant←g, and the FSM moves to ST_CALC.
  - With no valid request, the FSM stays in ST_IDLE and all ready bits are 0.
- ST_CALC:
  - The divider is driven from the latched operands.
  - The quotient, remainder, div_zero flag and ID are registered, and the FSM moves to ST_RESP.
- ST_RESP:
  - rsp_valid_out=1 and all response fields are held stable.
  - When rsp_ready_in=1, the FSM moves to ST_IDLE; otherwise it stays in ST_RESP indefinitely.
- req_ready_out is 0 in ST_CALC and ST_RESP.
- Requesters hold valid and operands until handshake.
- Zero denominator:
  - The divider denominator input is forced to 1, so the datapath never sees 0.
  - Response: quotient = all ones, remainder = numerator, rsp_div_zero_out=1.
- The round-robin pointer advances only on a grant. With a single persistent requester, that requester is granted every time.
- Reset values:
  - rsp_valid_out=0, rsp_id_out=0, rsp_quotient_out=0, rsp_remainder_out=0, rsp_div_zero_out=0
  - req_ready_out=0
  - last_grant=NUM_REQ-1, so requester 0 wins first.

## Timing
- Request accepted in cycle N → rsp_valid_out high in cycle N+2.
- Minimum spacing between grants is 3 cycles: accept, calc, respond with immediate ready.
- Back-pressure on rsp_ready_in stalls the FSM; no new grant is issued while stalled.
- Simultaneous requests: exactly one grant per ST_IDLE cycle. The others keep valid high and are served in round-robin order.
- rst asserted in any state:
  - Next cycle the FSM is in ST_IDLE with all outputs at reset values.
  - The in-flight operation is discarded with no response.

## Configuration
- DIVIDER_ARBITER_PERF_EN defined adds two ports:
  - perf_op_cnt_out  out  32: increments on every grant.
  - perf_zero_cnt_out  out  32: increments on every grant with a zero denominator.
- Both counters saturate at 32'hFFFF_FFFF and clear to 0 on rst.
- DIVIDER_ARBITER_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package divider_pkg holds:
  - typedef enum logic [1:0] div_arb_state_e {ST_IDLE, ST_CALC, ST_RESP}
  - localparam PERF_CNT_WIDTH=32
- Sub-module div_rr_arbiter:
  - Parameterised by NUM_REQ.
  - Inputs: request vector, last_grant, enable.
  - Outputs: one-hot grant and encoded grant index.
- Top level instantiates div_rr_arbiter and one `divider`.

## Test plan
- Reset then single request: req0 valid with 100/7 in cycle N → ready0 in cycle N; rsp in N+2 with id=0, q=14, r=2, div_zero=0.
- Round-robin fairness: all 4 valid continuously with rsp_ready_in=1 → grant order 0,1,2,3,0, each grant 3 cycles apart.
- Divide by zero: req2 with 55/0 → q=8'hFF, r=55, div_zero=1, id=2; the divider never sees a zero denominator, so there is no $fatal.
- Back-pressure: rsp_ready_in=0 for 5 cycles in ST_RESP → response fields stable, no req_ready_out asserted; ready=1 → next grant the following cycle.
- Reset mid-operation: rst in ST_CALC → next cycle rsp_valid_out=0, FSM in ST_IDLE, next grant goes to req0; no response for the discarded op.
- With DIVIDER_ARBITER_PERF_EN: 10 grants including 3 with zero denominator → perf_op_cnt_out=10, perf_zero_cnt_out=3; rst → both 0.
